systolic_ctrl: RTL and testbench

SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

---
 rtl/systolic_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_systolic_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_ctrl.sv
// Sequencer for a 1-D chain of PEs: loads weights and biases, streams activations
// with per-PE delayed accumulate strobes, drains the pipeline, then reads results out.
module systolic_ctrl #(
  parameter int N_PE  = 4,
  parameter int IDX_W = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  reuse_w,
  input  logic [7:0]            k_len,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [7:0]            cfg_data,
  input  logic                  din_valid,
  output logic                  din_ready,
  input  logic [7:0]            din_data,
  output logic [7:0]            pe_weight,
  output logic [7:0]            pe_bias,
  output logic [7:0]            pe_data,
  output logic [N_PE-1:0]       pe_weight_en,
  output logic [N_PE-1:0]       pe_bias_en,
  output logic [N_PE-1:0]       pe_acc_w_en,
  input  logic [16*N_PE-1:0]    pe_acc_in,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [15:0]           res_data,
  output logic [IDX_W-1:0]      res_idx,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    LOAD_B,
    STREAM,
    DRAIN,
    READ
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [7:0]       cnt_reg;
  logic [7:0]       cnt_next;
  logic [7:0]       k_len_reg;
  logic [IDX_W-1:0] idx_next;
  logic             res_load;
  logic             cfg_fire;
  logic             din_fire;
  logic             res_fire;
  logic             last_idx;
  logic [N_PE-1:0]  weight_en_next;
  logic [N_PE-1:0]  bias_en_next;
  logic [15:0]      acc_word [N_PE];

  assign cfg_ready = (state_reg == LOAD_W) || (state_reg == LOAD_B);
  assign din_ready = (state_reg == STREAM) && (cnt_reg < k_len_reg);
  assign res_valid = (state_reg == READ);

  assign cfg_fire = cfg_valid && cfg_ready;
  assign din_fire = din_valid && din_ready;
  assign res_fire = res_valid && res_ready;
  assign last_idx = (res_idx == IDX_W'(N_PE - 1));

  // Config beat j addresses PE j; the beat counter doubles as the one-hot select.
  generate
    for (genvar gi = 0; gi < N_PE; gi++) begin : g_pe
      assign acc_word[gi]       = pe_acc_in[16*gi +: 16];
      assign weight_en_next[gi] = cfg_fire && (state_reg == LOAD_W) && (cnt_reg == 8'(gi));
      assign bias_en_next[gi]   = cfg_fire && (state_reg == LOAD_B) && (cnt_reg == 8'(gi));
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = res_idx;
    res_load   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = reuse_w ? LOAD_B : LOAD_W;
          cnt_next   = '0;
        end
      end
      LOAD_W: begin
        if (cfg_fire) begin
          if (cnt_reg == 8'(N_PE - 1)) begin
            state_next = LOAD_B;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 8'd1;
          end
        end
      end
      LOAD_B: begin
        if (cfg_fire) begin
          if (cnt_reg == 8'(N_PE - 1)) begin
            state_next = STREAM;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 8'd1;
          end
        end
      end
      STREAM: begin
        // cnt never exceeds k_len here, so cnt+1 cannot wrap even at k_len=255.
        if (cnt_reg >= k_len_reg) begin
          state_next = DRAIN;
          cnt_next   = '0;
        end else if (din_fire) begin
          if (cnt_reg + 8'd1 == k_len_reg) begin
            state_next = DRAIN;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 8'd1;
          end
        end
      end
      DRAIN: begin
        if (cnt_reg == 8'(N_PE)) begin
          state_next = READ;
          cnt_next   = '0;
          idx_next   = '0;
          res_load   = 1'b1;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      READ: begin
        if (res_fire) begin
          if (last_idx) begin
            state_next = IDLE;
          end else begin
            idx_next = res_idx + IDX_W'(1);
            res_load = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      k_len_reg    <= '0;
      pe_weight    <= '0;
      pe_bias      <= '0;
      pe_data      <= '0;
      pe_weight_en <= '0;
      pe_bias_en   <= '0;
      pe_acc_w_en  <= '0;
      res_data     <= '0;
      res_idx      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      pe_weight_en <= weight_en_next;
      pe_bias_en   <= bias_en_next;
      // Enable travels one PE per cycle, matching the data pass-through in the chain.
      pe_acc_w_en  <= {pe_acc_w_en[N_PE-2:0], din_fire};
      busy         <= (state_next != IDLE);
      done         <= (state_reg == READ) && (state_next == IDLE);
      if ((state_reg == IDLE) && start) begin
        k_len_reg <= k_len;
      end
      if (cfg_fire && (state_reg == LOAD_W)) begin
        pe_weight <= cfg_data;
      end
      if (cfg_fire && (state_reg == LOAD_B)) begin
        pe_bias <= cfg_data;
      end
      if (din_fire) begin
        pe_data <= din_data;
      end
      if (res_load) begin
        res_idx  <= idx_next;
        res_data <= acc_word[idx_next];
      end
    end
  end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed bench for systolic_ctrl: job vectors with hand-computed results driven
// against a behavioural 4-PE chain, plus reset and enable-timing sequences.
module tb_systolic_ctrl;
  localparam int N  = 4;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           start = 1'b0;
  logic           reuse_w = 1'b0;
  logic [7:0]     k_len = '0;
  logic           cfg_valid = 1'b0;
  logic           cfg_ready;
  logic [7:0]     cfg_data = '0;
  logic           din_valid = 1'b0;
  logic           din_ready;
  logic [7:0]     din_data = '0;
  logic [7:0]     pe_weight, pe_bias, pe_data;
  logic [N-1:0]   pe_weight_en, pe_bias_en, pe_acc_w_en;
  logic [16*N-1:0] pe_acc_in;
  logic           res_valid;
  logic           res_ready = 1'b0;
  logic [15:0]    res_data;
  logic [IW-1:0]  res_idx;
  logic           busy, done;

  int checks = 0;
  int errors = 0;
  int din_acc = 0;
  int wen_pulses = 0;
  int done_cnt = 0;
  int overlap_cnt = 0;

  systolic_ctrl #(.N_PE(N), .IDX_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .reuse_w(reuse_w), .k_len(k_len),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
    .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data),
    .pe_weight(pe_weight), .pe_bias(pe_bias), .pe_data(pe_data),
    .pe_weight_en(pe_weight_en), .pe_bias_en(pe_bias_en), .pe_acc_w_en(pe_acc_w_en),
    .pe_acc_in(pe_acc_in), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_idx(res_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // PE chain: data passes one PE per cycle; bias load overwrites the accumulator.
  logic signed [7:0]  w_m    [N];
  logic signed [15:0] acc_m  [N];
  logic signed [7:0]  d_pipe [N];

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      logic signed [7:0] dv;
      dv = (i == 0) ? $signed(pe_data) : d_pipe[i];
      if (pe_weight_en[i]) w_m[i] <= $signed(pe_weight);
      if (pe_bias_en[i]) acc_m[i] <= {{8{pe_bias[7]}}, pe_bias};
      else if (pe_acc_w_en[i]) acc_m[i] <= acc_m[i] + w_m[i] * dv;
    end
    for (int i = 1; i < N; i++) d_pipe[i] <= (i == 1) ? $signed(pe_data) : d_pipe[i-1];
  end

  always_comb begin
    pe_acc_in = '0;
    for (int i = 0; i < N; i++) pe_acc_in[16*i +: 16] = acc_m[i];
  end

  always @(posedge clk) begin
    if (din_valid && din_ready) din_acc++;
    if (|pe_weight_en) wen_pulses++;
    if (done) done_cnt++;
  end

  always @(negedge clk) begin
    if (rst_n && |(pe_bias_en & pe_acc_w_en)) overlap_cnt++;
  end

  typedef struct packed {
    logic             reuse;
    logic [7:0]       k;
    logic [3:0][7:0]  w;
    logic [3:0][7:0]  b;
    logic [7:0][7:0]  din;
    logic             gap;
    logic             stall;
    logic             timing;
    logic             ign;
    logic [3:0][15:0] res;
  } vec_t;

  vec_t vecs [7];

  function automatic vec_t mk(input logic reuse, input logic [7:0] k, input logic [31:0] w,
                              input logic [31:0] b, input logic [63:0] din, input logic gap,
                              input logic stall, input logic timing, input logic ign,
                              input logic [63:0] res);
    vec_t v;
    v.reuse = reuse; v.k = k; v.w = w; v.b = b; v.din = din;
    v.gap = gap; v.stall = stall; v.timing = timing; v.ign = ign; v.res = res;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out got 0 expected 1", name);
  endtask

  task automatic check_zero(input string name);
    chk(name, {pe_weight, pe_bias, pe_data, pe_weight_en, pe_bias_en, pe_acc_w_en,
               res_data, res_idx, busy, done, cfg_ready, din_ready, res_valid}, 64'd0);
  endtask

  task automatic send_cfg(input logic [7:0] d, input bit is_bias, input int j, input bit pulse);
    cfg_valid = 1'b1;
    cfg_data  = d;
    start     = pulse;
    if (pulse) k_len = 8'd7;
    for (int c = 0; c < 20 && !cfg_ready; c++) tick();
    if (!cfg_ready) begin
      timeout("cfg_ready");
      cfg_valid = 1'b0;
      start = 1'b0;
      return;
    end
    tick();
    cfg_valid = 1'b0;
    start = 1'b0;
    if (is_bias) begin
      chk("bias_en", pe_bias_en, 64'(1) << j);
      chk("bias", pe_bias, d);
      chk("weight_en_quiet", pe_weight_en, 0);
    end else begin
      chk("weight_en", pe_weight_en, 64'(1) << j);
      chk("weight", pe_weight, d);
      chk("bias_en_quiet", pe_bias_en, 0);
    end
  endtask

  task automatic send_din(input logic [7:0] d, output bit ok);
    din_valid = 1'b1;
    din_data  = d;
    for (int c = 0; c < 20 && !din_ready; c++) tick();
    ok = din_ready;
    if (!ok) begin
      timeout("din_ready");
      din_valid = 1'b0;
      return;
    end
    tick();
    din_valid = 1'b0;
    chk("pe_data", pe_data, d);
  endtask

  task automatic run_job(input vec_t v, input int id);
    int base_acc, base_done, base_wen;
    bit ok;
    logic [7:0] d;
    logic [15:0] got [4];
    base_acc  = din_acc;
    base_done = done_cnt;
    base_wen  = wen_pulses;

    start = 1'b1; reuse_w = v.reuse; k_len = v.k;
    tick();
    start = 1'b0; k_len = 8'hAA;
    chk("busy_start", busy, 1);

    if (!v.reuse) for (int j = 0; j < N; j++) send_cfg(v.w[j], 1'b0, j, 1'b0);
    for (int j = 0; j < N; j++) send_cfg(v.b[j], 1'b1, j, v.ign && (j == 1));

    for (int j = 0; j < int'(v.k); j++) begin
      d = (v.k > 8) ? v.din[0] : v.din[j];
      send_din(d, ok);
      if (!ok) return;
      if (v.timing) begin
        for (int i = 0; i < N; i++) begin
          chk("acc_w_en_timing", pe_acc_w_en, 64'(1) << i);
          tick();
        end
        chk("acc_w_en_retired", pe_acc_w_en, 0);
        chk("drain_not_done", res_valid, 0);
        tick();
        chk("read_entry", res_valid, 1);
      end
      if (v.gap) begin
        tick();
        chk("pe_data_hold", pe_data, d);
        chk("acc_w_en0_gap", pe_acc_w_en[0], 0);
      end
    end

    din_valid = 1'b1;
    for (int c = 0; c < 3; c++) tick();
    din_valid = 1'b0;
    chk("din_beats", din_acc - base_acc, v.k);

    for (int c = 0; c < 40 && !res_valid; c++) tick();
    if (!res_valid) begin
      timeout("res_valid");
      return;
    end

    for (int i = 0; i < N; i++) begin
      res_ready = 1'b1;
      chk("res_valid", res_valid, 1);
      chk("res_idx", res_idx, i);
      chk("res_data", res_data, v.res[i]);
      got[i] = res_data;
      if (i == 0) chk("ready_quiet", {cfg_ready, din_ready}, 0);
      if (v.stall && i == 1) begin
        res_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          tick();
          chk("stall_idx", res_idx, i);
          chk("stall_data", res_data, v.res[i]);
          chk("stall_strobes", {pe_weight_en, pe_bias_en, pe_acc_w_en}, 0);
        end
        res_ready = 1'b1;
      end
      if (v.ign && i == 2) begin
        start = 1'b1;
        k_len = 8'd9;
      end
      tick();
      start = 1'b0;
    end
    res_ready = 1'b0;
    chk("done_pulse", done, 1);
    chk("busy_end", busy, 0);
    chk("res_valid_end", res_valid, 0);
    tick();
    chk("done_single", done, 0);
    chk("busy_idle", busy, 0);
    chk("done_count", done_cnt - base_done, 1);
    if (v.reuse) chk("no_weight_en", wen_pulses - base_wen, 0);
    $display("job %0d reuse=%0b k_len=%0d results %h %h %h %h", id, v.reuse, v.k,
             got[0], got[1], got[2], got[3]);
  endtask

  initial begin
    bit ok;
    vecs[0] = mk(1'b0, 8'd3, {8'd4, 8'd3, 8'd2, 8'd1}, {8'd40, 8'd30, 8'd20, 8'd10},
                 {40'h0, 8'd7, 8'd6, 8'd5}, 1'b0, 1'b1, 1'b0, 1'b0,
                 {16'd112, 16'd84, 16'd56, 16'd28});
    vecs[1] = mk(1'b0, 8'd3, {8'd4, 8'd3, 8'd2, 8'd1}, {8'd40, 8'd30, 8'd20, 8'd10},
                 {40'h0, 8'd7, 8'd6, 8'd5}, 1'b1, 1'b0, 1'b0, 1'b0,
                 {16'd112, 16'd84, 16'd56, 16'd28});
    vecs[2] = mk(1'b1, 8'd0, 32'h0, {8'h02, 8'h01, 8'h00, 8'hFF},
                 64'h0, 1'b0, 1'b0, 1'b0, 1'b0,
                 {16'h0002, 16'h0001, 16'h0000, 16'hFFFF});
    vecs[3] = mk(1'b0, 8'd2, {8'h05, 8'h00, 8'h03, 8'hFE}, {4{8'h01}},
                 {48'h0, 8'h0A, 8'hFD}, 1'b0, 1'b0, 1'b0, 1'b1,
                 {16'h0024, 16'h0001, 16'h0016, 16'hFFF3});
    vecs[4] = mk(1'b0, 8'd1, {8'd4, 8'd3, 8'd2, 8'd1}, 32'h0,
                 {56'h0, 8'd3}, 1'b0, 1'b0, 1'b1, 1'b0,
                 {16'd12, 16'd9, 16'd6, 16'd3});
    vecs[5] = mk(1'b0, 8'd3, {8'd4, 8'd3, 8'd2, 8'd1}, {8'd40, 8'd30, 8'd20, 8'd10},
                 {40'h0, 8'd7, 8'd6, 8'd5}, 1'b0, 1'b0, 1'b0, 1'b0,
                 {16'd112, 16'd84, 16'd56, 16'd28});
    vecs[6] = mk(1'b1, 8'd255, 32'h0, 32'h0,
                 {56'h0, 8'd1}, 1'b0, 1'b0, 1'b0, 1'b0,
                 {16'h03FC, 16'h02FD, 16'h01FE, 16'h00FF});

    #2 rst_n = 1'b0;
    #1 check_zero("reset_init");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_zero("idle_after_reset");

    for (int i = 0; i < 5; i++) run_job(vecs[i], i);

    // Reset while streaming: abandon job after two beats.
    start = 1'b1; reuse_w = 1'b0; k_len = 8'd5;
    tick();
    start = 1'b0;
    for (int j = 0; j < N; j++) send_cfg(8'(j + 1), 1'b0, j, 1'b0);
    for (int j = 0; j < N; j++) send_cfg(8'd0, 1'b1, j, 1'b0);
    for (int j = 0; j < 2; j++) send_din(8'd9, ok);
    din_valid = 1'b1;
    chk("busy_pre_rst", busy, 1);
    chk("acc_w_en_pre_rst", pe_acc_w_en, 4'b0011);
    rst_n = 1'b0;
    #1 check_zero("reset_mid_stream");
    din_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("busy_post_rst", busy, 0);
    $display("reset during STREAM applied");

    for (int i = 5; i < 7; i++) run_job(vecs[i], i);

    chk("bias_acc_overlap", overlap_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
